// File: rtl/dff_response_checker.sv
// rtl/dff_response_checker.sv - compares a DUT output against its reference input delayed by LATENCY clocks
module dff_response_checker #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1,
    parameter int ERR_W   = 8,
    parameter int CYC_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] d_ref,
    input  logic [WIDTH-1:0] q_obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CYC_W-1:0] first_err_cycle
);

    typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE_S} state_t;

    localparam logic [3:0] FILL_LAST = 4'(LATENCY - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] hist [LATENCY];
    logic [3:0]       fill_cnt;
    logic [CYC_W-1:0] cyc_cnt;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    assign busy = (state == FILL) || (state == CHECK);
    assign done = (state == DONE_S);

    // Case inequality so an unknown DUT output is scored as a mismatch.
    assign mismatch = (state == CHECK) && (q_obs !== hist[LATENCY-1]);
    assign err_next = (mismatch && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FILL;
            FILL: begin
                if (stop)                        state_next = DONE_S;
                else if (fill_cnt == FILL_LAST)  state_next = CHECK;
            end
            CHECK:   if (stop) state_next = DONE_S;
            DONE_S:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // hist[0] is the newest sample; the tail is d_ref from LATENCY edges ago.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) hist[i] <= '0;
        end else if (busy) begin
            hist[0] <= d_ref;
            for (int i = 1; i < LATENCY; i++) hist[i] <= hist[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt        <= '0;
            cyc_cnt         <= '0;
            err_cnt         <= '0;
            first_err_cycle <= '0;
            pass            <= 1'b0;
            fail            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        fill_cnt        <= '0;
                        cyc_cnt         <= '0;
                        err_cnt         <= '0;
                        first_err_cycle <= '0;
                        pass            <= 1'b0;
                        fail            <= 1'b0;
                    end
                end
                FILL: fill_cnt <= fill_cnt + 4'd1;
                CHECK: begin
                    err_cnt <= err_next;
                    // err_cnt never returns to zero once set, so zero marks "no mismatch yet".
                    if (mismatch && (err_cnt == '0)) first_err_cycle <= cyc_cnt;
                    if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
                    // Reaching CHECK with stop means at least this cycle was compared.
                    if (stop) begin
                        pass <= (err_next == '0);
                        fail <= (err_next != '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_response_checker.sv
// tb/tb_dff_response_checker.sv - directed vector bench for dff_response_checker
module tb_dff_response_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: WIDTH=4, LATENCY=1, bench DFF with optional output inversion
    logic        start_a = 1'b0, stop_a = 1'b0, inv_a = 1'b0;
    logic [3:0]  d_a = 4'd0, dff_a, q_a;
    logic        busy_a, done_a, pass_a, fail_a;
    logic [7:0]  err_a;
    logic [15:0] fec_a;
    always @(posedge clk) dff_a <= d_a;
    assign q_a = dff_a ^ {4{inv_a}};

    // Instance B: WIDTH=4, LATENCY=3, bench 3-stage pipe
    logic        start_b = 1'b0, stop_b = 1'b0;
    logic [3:0]  d_b = 4'd0, p0, p1, p2;
    logic        busy_b, done_b, pass_b, fail_b;
    logic [7:0]  err_b;
    logic [15:0] fec_b;
    always @(posedge clk) begin
        p0 <= d_b;
        p1 <= p0;
        p2 <= p1;
    end

    // Instance C: WIDTH=1, ERR_W=2, always-inverting DFF
    logic        start_c = 1'b0, stop_c = 1'b0;
    logic        d_c = 1'b0, dff_c, q_c;
    logic        busy_c, done_c, pass_c, fail_c;
    logic [1:0]  err_c;
    logic [15:0] fec_c;
    always @(posedge clk) dff_c <= d_c;
    assign q_c = ~dff_c;

    dff_response_checker #(.WIDTH(4), .LATENCY(1), .ERR_W(8), .CYC_W(16)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .d_ref(d_a), .q_obs(q_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a),
        .err_cnt(err_a), .first_err_cycle(fec_a));

    dff_response_checker #(.WIDTH(4), .LATENCY(3), .ERR_W(8), .CYC_W(16)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .d_ref(d_b), .q_obs(p2),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
        .err_cnt(err_b), .first_err_cycle(fec_b));

    dff_response_checker #(.WIDTH(1), .LATENCY(1), .ERR_W(2), .CYC_W(16)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .stop(stop_c), .d_ref(d_c), .q_obs(q_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .fail(fail_c),
        .err_cnt(err_c), .first_err_cycle(fec_c));

    typedef struct {
        logic        start;
        logic        stop;
        logic [3:0]  d;
        logic        inv;
        logic        busy;
        logic        done;
        logic        pass;
        logic        fail;
        logic [7:0]  err;
        logic [15:0] fec;
    } vec_t;

    vec_t tbl [17];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic s, input logic st, input logic [3:0] d, input logic inv,
                                input logic b, input logic dn, input logic p, input logic f,
                                input logic [7:0] e, input logic [15:0] c);
        vec_t v;
        v.start = s; v.stop = st; v.d = d; v.inv = inv;
        v.busy = b; v.done = dn; v.pass = p; v.fail = f; v.err = e; v.fec = c;
        return v;
    endfunction

    function automatic logic [27:0] pk(input logic b, input logic dn, input logic p, input logic f,
                                       input logic [7:0] e, input logic [15:0] c);
        return {b, dn, p, f, e, c};
    endfunction

    function automatic logic [27:0] got_a();
        return pk(busy_a, done_a, pass_a, fail_a, err_a, fec_a);
    endfunction

    function automatic logic [27:0] got_b();
        return pk(busy_b, done_b, pass_b, fail_b, err_b, fec_b);
    endfunction

    function automatic logic [27:0] got_c();
        return pk(busy_c, done_c, pass_c, fail_c, {6'd0, err_c}, fec_c);
    endfunction

    task automatic chk(input string name, input logic [27:0] got, input logic [27:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got busy=%b done=%b pass=%b fail=%b err_cnt=%0d first_err_cycle=%0d, expected busy=%b done=%b pass=%b fail=%b err_cnt=%0d first_err_cycle=%0d",
                     name, got[27], got[26], got[25], got[24], got[23:16], got[15:0],
                     exp[27], exp[26], exp[25], exp[24], exp[23:16], exp[15:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             start stop d   inv  busy done pass fail err fec
        tbl[0]  = mk(1, 0, 4'h3, 0,  1, 0, 0, 0, 8'd0, 16'd0);
        tbl[1]  = mk(0, 0, 4'h5, 0,  1, 0, 0, 0, 8'd0, 16'd0);
        tbl[2]  = mk(0, 0, 4'h6, 0,  1, 0, 0, 0, 8'd0, 16'd0);
        tbl[3]  = mk(0, 0, 4'h9, 1,  1, 0, 0, 0, 8'd1, 16'd1);
        tbl[4]  = mk(0, 0, 4'hA, 0,  1, 0, 0, 0, 8'd1, 16'd1);
        tbl[5]  = mk(0, 0, 4'hC, 1,  1, 0, 0, 0, 8'd2, 16'd1);
        tbl[6]  = mk(0, 1, 4'h0, 0,  0, 1, 0, 1, 8'd2, 16'd1);
        tbl[7]  = mk(0, 0, 4'h0, 0,  0, 0, 0, 1, 8'd2, 16'd1);
        tbl[8]  = mk(0, 1, 4'h0, 0,  0, 0, 0, 1, 8'd2, 16'd1);
        tbl[9]  = mk(1, 1, 4'h7, 0,  1, 0, 0, 0, 8'd0, 16'd0);
        tbl[10] = mk(1, 0, 4'h7, 0,  1, 0, 0, 0, 8'd0, 16'd0);
        tbl[11] = mk(1, 0, 4'h1, 0,  1, 0, 0, 0, 8'd0, 16'd0);
        tbl[12] = mk(0, 1, 4'h2, 0,  0, 1, 1, 0, 8'd0, 16'd0);
        tbl[13] = mk(0, 0, 4'h0, 0,  0, 0, 1, 0, 8'd0, 16'd0);
        tbl[14] = mk(1, 0, 4'h0, 0,  1, 0, 0, 0, 8'd0, 16'd0);
        tbl[15] = mk(0, 1, 4'h0, 0,  0, 1, 0, 0, 8'd0, 16'd0);
        tbl[16] = mk(0, 0, 4'h0, 0,  0, 0, 0, 0, 8'd0, 16'd0);

        // Asynchronous reset between clock edges
        #3 rst = 1'b0;
        #1;
        chk("reset_a", got_a(), pk(0, 0, 0, 0, 8'd0, 16'd0));
        chk("reset_b", got_b(), pk(0, 0, 0, 0, 8'd0, 16'd0));
        chk("reset_c", got_c(), pk(0, 0, 0, 0, 8'd0, 16'd0));
        #8 rst = 1'b1;
        tick();
        chk("idle_after_reset", got_a(), pk(0, 0, 0, 0, 8'd0, 16'd0));

        for (int i = 0; i < 17; i++) begin
            start_a = tbl[i].start;
            stop_a  = tbl[i].stop;
            d_a     = tbl[i].d;
            inv_a   = tbl[i].inv;
            tick();
            chk($sformatf("tbl[%0d]", i), got_a(),
                pk(tbl[i].busy, tbl[i].done, tbl[i].pass, tbl[i].fail, tbl[i].err, tbl[i].fec));
        end
        start_a = 1'b0; stop_a = 1'b0; inv_a = 1'b0;

        // Ideal DFF: one fill cycle, 20 random check cycles, then stop
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int k = 0; k < 21; k++) begin
            d_a = 4'($urandom);
            tick();
        end
        chk("ideal_running", got_a(), pk(1, 0, 0, 0, 8'd0, 16'd0));
        stop_a = 1'b1; d_a = 4'($urandom); tick(); stop_a = 1'b0;
        chk("ideal_done", got_a(), pk(0, 1, 1, 0, 8'd0, 16'd0));
        tick();
        chk("ideal_done_pulse", got_a(), pk(0, 0, 1, 0, 8'd0, 16'd0));

        // Inverted output on check cycles 5 and 9 only
        start_a = 1'b1; tick(); start_a = 1'b0;
        d_a = 4'($urandom); tick();
        for (int k = 0; k < 12; k++) begin
            d_a   = 4'($urandom);
            inv_a = (k == 5) || (k == 9);
            tick();
        end
        inv_a = 1'b0; stop_a = 1'b1; tick(); stop_a = 1'b0;
        chk("inv_5_9", got_a(), pk(0, 1, 0, 1, 8'd2, 16'd5));

        // LATENCY=3: stop in the first check cycle gives exactly one compare
        start_b = 1'b1; d_b = 4'd1; tick(); start_b = 1'b0;
        chk("lat3_fill", got_b(), pk(1, 0, 0, 0, 8'd0, 16'd0));
        d_b = 4'd2; tick();
        d_b = 4'd3; tick();
        d_b = 4'd4; tick();
        chk("lat3_check", got_b(), pk(1, 0, 0, 0, 8'd0, 16'd0));
        stop_b = 1'b1; d_b = 4'd5; tick(); stop_b = 1'b0;
        chk("lat3_one_compare", got_b(), pk(0, 1, 1, 0, 8'd0, 16'd0));
        tick();
        chk("lat3_idle", got_b(), pk(0, 0, 1, 0, 8'd0, 16'd0));

        // LATENCY=3: stop during fill is inconclusive
        start_b = 1'b1; tick(); start_b = 1'b0;
        stop_b = 1'b1; tick(); stop_b = 1'b0;
        chk("lat3_stop_in_fill", got_b(), pk(0, 1, 0, 0, 8'd0, 16'd0));
        tick();
        chk("lat3_stop_in_fill_idle", got_b(), pk(0, 0, 0, 0, 8'd0, 16'd0));

        // ERR_W=2 saturation with constantly inverted output
        start_c = 1'b1; tick(); start_c = 1'b0;
        d_c = 1'($urandom); tick();
        for (int k = 0; k < 10; k++) begin
            d_c = 1'($urandom);
            tick();
            chk($sformatf("sat[%0d]", k), got_c(),
                pk(1, 0, 0, 0, (k >= 2) ? 8'd3 : 8'(k + 1), 16'd0));
        end
        stop_c = 1'b1; tick(); stop_c = 1'b0;
        chk("sat_done", got_c(), pk(0, 1, 0, 1, 8'd3, 16'd0));

        // Second start mid-CHECK ignored, then reset mid-CHECK aborts without done
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        inv_a = 1'b1; tick();
        tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("restart_ignored", got_a(), pk(1, 0, 0, 0, 8'd3, 16'd0));
        inv_a = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("reset_mid_check", got_a(), pk(0, 0, 0, 0, 8'd0, 16'd0));
        tick();
        chk("reset_held", got_a(), pk(0, 0, 0, 0, 8'd0, 16'd0));
        #3 rst = 1'b1;
        tick();
        chk("after_abort_no_done", got_a(), pk(0, 0, 0, 0, 8'd0, 16'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
